// File: rtl/predecode_queue_pkg.sv
// Shared constants and types for the predecoding instruction queue:
// RV32 opcodes, funct3 values, the canonical nop, class bit positions
// and the predecode result record stored with every queue entry.
package predecode_queue_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct3 values (instr[14:12]) the predecoder cares about
  localparam logic [2:0] F3_SLL      = 3'b001;
  localparam logic [2:0] F3_SRL_SRA  = 3'b101;
  localparam logic [2:0] F3_FENCE    = 3'b000;
  localparam logic [2:0] F3_FENCEI   = 3'b001;
  localparam logic [2:0] F3_PRIV     = 3'b000;
  localparam logic [2:0] F3_SYS_RSVD = 3'b100;

  // Privileged encodings in instr[31:20] when SYSTEM funct3 is zero
  localparam logic [11:0] SYS_ECALL  = 12'h000;
  localparam logic [11:0] SYS_EBREAK = 12'h001;
  localparam logic [11:0] SYS_MRET   = 12'h302;
  localparam logic [11:0] SYS_WFI    = 12'h105;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Bit positions inside the one-hot class vector
  localparam int CLS_ALU    = 0;
  localparam int CLS_JUMP   = 1;
  localparam int CLS_BRANCH = 2;
  localparam int CLS_LOAD   = 3;
  localparam int CLS_STORE  = 4;
  localparam int CLS_MULDIV = 5;
  localparam int CLS_CSR    = 6;
  localparam int CLS_SYSTEM = 7;

  // Predecode result kept next to each queued instruction
  typedef struct packed {
    logic [7:0] instr_class;
    logic       illegal;
  } predecode_out_type;

endpackage

// File: rtl/predecode_queue_predecoder.sv
// Combinational predecoder: classifies one instruction into a one-hot
// class and flags encodings the core does not implement.
module predecode_queue_predecoder
  import predecode_queue_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1,
  parameter bit FENCEI_EN = 1'b1
) (
  input  logic [31:0]       instr,
  output predecode_out_type pd
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [7:0] cls;
  logic       bad;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Register and immediate fields other than those below never affect class
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  // Pick the class from the opcode, then veto it for reserved encodings
  always_comb begin
    cls = '0;
    bad = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: cls[CLS_ALU] = 1'b1;
      OPC_OP_IMM: begin
        cls[CLS_ALU] = 1'b1;
        if ((funct3 == F3_SLL || funct3 == F3_SRL_SRA) && instr[25]) bad = 1'b1;
      end
      OPC_OP: begin
        if (instr[25]) begin
          cls[CLS_MULDIV] = 1'b1;
          if (!MULDIV_EN) bad = 1'b1;
        end else begin
          cls[CLS_ALU] = 1'b1;
        end
      end
      OPC_JAL, OPC_JALR: cls[CLS_JUMP] = 1'b1;
      OPC_BRANCH: begin
        cls[CLS_BRANCH] = 1'b1;
        if (funct3 == 3'd2 || funct3 == 3'd3) bad = 1'b1;
      end
      OPC_LOAD: begin
        cls[CLS_LOAD] = 1'b1;
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) bad = 1'b1;
      end
      OPC_STORE: begin
        cls[CLS_STORE] = 1'b1;
        if (funct3 >= 3'd3) bad = 1'b1;
      end
      OPC_MISC_MEM: begin
        cls[CLS_ALU] = 1'b1;
        if (!(funct3 == F3_FENCE || (funct3 == F3_FENCEI && FENCEI_EN))) bad = 1'b1;
      end
      OPC_SYSTEM: begin
        if (funct3 == F3_SYS_RSVD) begin
          bad = 1'b1;
        end else if (funct3 == F3_PRIV) begin
          cls[CLS_SYSTEM] = 1'b1;
          if (!(instr[31:20] == SYS_ECALL || instr[31:20] == SYS_EBREAK ||
                instr[31:20] == SYS_MRET  || instr[31:20] == SYS_WFI)) bad = 1'b1;
        end else begin
          cls[CLS_CSR] = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
    pd.illegal     = bad;
    pd.instr_class = bad ? 8'h00 : cls;
  end

endmodule

// File: rtl/predecode_queue.sv
// Fetch-to-decode instruction FIFO. Instructions are predecoded on the way
// in so decode can steer on the stored class one cycle after enqueue.
module predecode_queue
  import predecode_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter bit          MULDIV_EN = 1'b1,
  parameter bit          FENCEI_EN = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [7:0]               out_class,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]       instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];
  predecode_out_type pd_mem    [DEPTH];

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  predecode_out_type in_pd;
  logic              do_enq;
  logic              do_deq;

  predecode_queue_predecoder #(
    .MULDIV_EN (MULDIV_EN),
    .FENCEI_EN (FENCEI_EN)
  ) u_predecoder (
    .instr (in_instr),
    .pd    (in_pd)
  );

  // Handshakes depend only on registered occupancy; flush cancels both sides
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign do_enq    = in_valid & in_ready & ~flush;
  assign do_deq    = out_valid & out_ready & ~flush;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PW'(1);
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
      if (do_enq && !do_deq)      count <= count + CW'(1);
      else if (!do_enq && do_deq) count <= count - CW'(1);
    end
  end

  // Entry storage is not reset; stale slots are hidden by the empty mux
  always_ff @(posedge clock) begin
    if (do_enq) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
      pd_mem[wr_ptr]    <= in_pd;
    end
  end

  // Head entry to decode, or the fixed idle values when the queue is empty
  always_comb begin
    out_instr   = NOP_INSTR;
    out_pc      = '0;
    out_class   = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_instr   = instr_mem[rd_ptr];
      out_pc      = pc_mem[rd_ptr];
      out_class   = pd_mem[rd_ptr].instr_class;
      out_illegal = pd_mem[rd_ptr].illegal;
    end
  end

endmodule

// File: tb/tb_predecode_queue.sv
// Bench for predecode_queue: two instances (M/fence.i on and off) share one
// stimulus stream and are compared against a queue-based reference model.
module tb_predecode_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_instr_a, out_pc_a;
  logic [7:0]  out_class_a;
  logic [2:0]  count_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [31:0] out_instr_b, out_pc_b;
  logic [7:0]  out_class_b;
  logic [2:0]  count_b;

  entry_t model_q[$];
  int     checks;
  int     failures;

  logic [6:0] op_table [11] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h6f, 7'h67,
                                7'h63, 7'h03, 7'h23, 7'h0f, 7'h73};

  predecode_queue #(.DEPTH(DEPTH), .MULDIV_EN(1'b1), .FENCEI_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(out_instr_a),
    .out_pc(out_pc_a), .out_class(out_class_a), .out_illegal(out_illegal_a),
    .count(count_a)
  );

  predecode_queue #(.DEPTH(DEPTH), .MULDIV_EN(1'b0), .FENCEI_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
    .out_pc(out_pc_b), .out_class(out_class_b), .out_illegal(out_illegal_b),
    .count(count_b)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference classification: returns {illegal, class[7:0]}
  function automatic logic [8:0] ref_predecode(logic [31:0] i, bit mul_en, bit fi_en);
    int f3;
    int bit_idx;
    f3 = int'(i[14:12]);
    bit_idx = -1;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h37, 7'h17: bit_idx = 0;
        7'h13:        bit_idx = ((f3 == 1 || f3 == 5) && i[25]) ? -1 : 0;
        7'h33:        bit_idx = i[25] ? (mul_en ? 5 : -1) : 0;
        7'h6f, 7'h67: bit_idx = 1;
        7'h63:        bit_idx = (f3 == 2 || f3 == 3) ? -1 : 2;
        7'h03:        bit_idx = (f3 == 3 || f3 == 6 || f3 == 7) ? -1 : 3;
        7'h23:        bit_idx = (f3 < 3) ? 4 : -1;
        7'h0f:        bit_idx = (f3 == 0 || (f3 == 1 && fi_en)) ? 0 : -1;
        7'h73: begin
          if (f3 == 4) bit_idx = -1;
          else if (f3 != 0) bit_idx = 6;
          else if (i[31:20] == 12'h000 || i[31:20] == 12'h001 ||
                   i[31:20] == 12'h302 || i[31:20] == 12'h105) bit_idx = 7;
          else bit_idx = -1;
        end
        default: bit_idx = -1;
      endcase
    end
    if (bit_idx < 0) return 9'h100;
    return {1'b0, 8'(1 << bit_idx)};
  endfunction

  // Random instruction biased toward real opcodes and privileged encodings
  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 15);
    if (sel < 11) begin
      w[6:0] = op_table[sel];
    end else if (sel < 14) begin
      case ($urandom_range(0, 4))
        0:       w = 32'h00000073;
        1:       w = 32'h00100073;
        2:       w = 32'h30200073;
        3:       w = 32'h10500073;
        default: w = {12'h7ff, 13'h0, 7'h73};
      endcase
    end
    return w;
  endfunction

  // One comparison: counts it and reports any difference
  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare one instance against the model head and occupancy
  task automatic compare_dut(string name, bit mul_en, bit fi_en,
                             logic ov, logic ir, logic [31:0] oi, logic [31:0] op,
                             logic [7:0] oc, logic oil, logic [2:0] cnt);
    logic [8:0]  pd;
    logic [31:0] e_instr, e_pc;
    logic [7:0]  e_cls;
    logic        e_ill;
    e_instr = 32'h00000013;
    e_pc    = 32'h0;
    e_cls   = 8'h00;
    e_ill   = 1'b0;
    if (model_q.size() != 0) begin
      pd      = ref_predecode(model_q[0].instr, mul_en, fi_en);
      e_instr = model_q[0].instr;
      e_pc    = model_q[0].pc;
      e_cls   = pd[7:0];
      e_ill   = pd[8];
    end
    check_output({name, ".count"},     32'(cnt), 32'(model_q.size()));
    check_output({name, ".out_valid"}, 32'(ov),  32'(model_q.size() != 0));
    check_output({name, ".in_ready"},  32'(ir),  32'(model_q.size() < DEPTH));
    check_output({name, ".out_instr"}, oi, e_instr);
    check_output({name, ".out_pc"},    op, e_pc);
    check_output({name, ".out_class"}, 32'(oc),  32'(e_cls));
    check_output({name, ".illegal"},   32'(oil), 32'(e_ill));
  endtask

  task automatic compare_all();
    compare_dut("a", 1'b1, 1'b1, out_valid_a, in_ready_a, out_instr_a, out_pc_a,
                out_class_a, out_illegal_a, count_a);
    compare_dut("b", 1'b0, 1'b0, out_valid_b, in_ready_b, out_instr_b, out_pc_b,
                out_class_b, out_illegal_b, count_b);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare
  task automatic apply_stimulus(logic v, logic [31:0] instr, logic [31:0] pc,
                                logic ordy, logic fl);
    bit can_enq;
    bit can_deq;
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clock);
    can_enq = (model_q.size() < DEPTH);
    can_deq = (model_q.size() != 0);
    if (fl) begin
      model_q.delete();
    end else begin
      if (ordy && can_deq) void'(model_q.pop_front());
      if (v && can_enq) model_q.push_back('{instr: instr, pc: pc});
    end
    #1;
    compare_all();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    check_output("reset.out_instr", out_instr_a, 32'h00000013);
    reset = 1'b1;
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_output("idle.in_ready", 32'(in_ready_a), 32'h1);

    // Single add becomes visible one cycle later
    apply_stimulus(1'b1, 32'h00A50533, 32'h100, 1'b0, 1'b0);
    check_output("add.class", 32'(out_class_a), 32'h01);
    check_output("add.pc", out_pc_a, 32'h100);
    check_output("add.count", 32'(count_a), 32'd1);

    // Fill to DEPTH, then a rejected fifth beat
    apply_stimulus(1'b1, 32'h00150513, 32'h104, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h0005A503, 32'h108, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00A5A023, 32'h10C, 1'b0, 1'b0);
    check_output("full.in_ready", 32'(in_ready_a), 32'h0);
    apply_stimulus(1'b1, 32'h0FFFF0B7, 32'h110, 1'b0, 1'b0);
    check_output("full.count", 32'(count_a), 32'd4);

    // One dequeue reopens the input; then stream through the pointer wrap
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_output("deq.in_ready", 32'(in_ready_a), 32'h1);
    check_output("deq.head_pc", out_pc_a, 32'h104);
    for (int k = 0; k < 6; k++)
      apply_stimulus(1'b1, 32'h00000013 + 32'(k << 20), 32'h200 + 32'(4 * k), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // mul is muldiv with M enabled, illegal without
    apply_stimulus(1'b1, 32'h02B50533, 32'h300, 1'b0, 1'b0);
    check_output("mul.class_m", 32'(out_class_a), 32'h20);
    check_output("mul.illegal_m", 32'(out_illegal_a), 32'h0);
    check_output("mul.class_nom", 32'(out_class_b), 32'h00);
    check_output("mul.illegal_nom", 32'(out_illegal_b), 32'h1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with three queued entries and a colliding enqueue/dequeue
    apply_stimulus(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00200113, 32'h404, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00300193, 32'h408, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00400213, 32'h40C, 1'b1, 1'b1);
    check_output("flush.count", 32'(count_a), 32'd0);
    check_output("flush.out_valid", 32'(out_valid_a), 32'h0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_output("flush.dropped", 32'(out_valid_a), 32'h0);

    // Privileged encodings and the all-zero word
    apply_stimulus(1'b1, 32'h30200073, 32'h500, 1'b0, 1'b0);
    check_output("mret.class", 32'(out_class_a), 32'h80);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h00100073, 32'h504, 1'b0, 1'b0);
    check_output("ebreak.class", 32'(out_class_a), 32'h80);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h00000000, 32'h508, 1'b0, 1'b0);
    check_output("zero.illegal", 32'(out_illegal_a), 32'h1);
    check_output("zero.class", 32'(out_class_a), 32'h00);

    // Asynchronous reset mid-operation empties the queue without a clock edge
    apply_stimulus(1'b1, 32'h00500293, 32'h600, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    model_q.delete();
    compare_all();
    @(posedge clock);
    #1;
    reset = 1'b1;
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++)
      apply_stimulus($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFFFFFC,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);

    $display("[TB] directed and random sequences complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/predecode_queue.md
Name: predecode_queue

Overview:
- Parametrised instruction queue between fetch and decode. Each instruction is predecoded as it is written into the queue.
- For every entry it stores the instruction, its PC, a one-hot instruction class and an illegal flag. Decode and hazard logic can then steer on the class without waiting for the full decoder.
- Valid/ready handshake on both sides. Synchronous flush for redirects (branch, jump, trap, mret).
- The M extension is selectable at elaboration.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- MULDIV_EN, 1, 1 = RV32M opcodes legal; 0 = flagged illegal.
- FENCEI_EN, 1, 1 = fence.i (funct3=1) legal; 0 = only fence (funct3=0) legal.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- flush  input  1  synchronous queue clear; highest priority
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept; equals (count < DEPTH)
- in_instr  input  32  fetched instruction
- in_pc  input  32  PC of in_instr
- out_valid  output  1  head entry is valid; equals (count != 0)
- out_ready  input  1  decode consumes the head
- out_instr  output  32  head instruction; 32'h00000013 (nop) when empty
- out_pc  output  32  head PC; 0 when empty
- out_class  output  8  one-hot {system,csr,muldiv,store,load,branch,jump,alu}; 0 when empty
- out_illegal  output  1  head is illegal; 0 when empty
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - read pointer, write pointer and count go to 0.
  - out_valid=0, in_ready=1, out_instr=nop, out_pc=0, out_class=0, out_illegal=0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately.
- Enqueue: when in_valid & in_ready at a clock edge, the entry is written at the write pointer and the write pointer increments, wrapping modulo DEPTH.
- Dequeue: when out_valid & out_ready at a clock edge, the read pointer increments, wrapping modulo DEPTH.
- Latency: no bypass. An instruction enqueued at edge N is visible on the out_* ports after edge N (one cycle). Outputs are driven from registered storage only.
- Full: in_ready=0 even if out_ready=1 in the same cycle. There is no combinational path from out_ready to in_ready.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Empty: out_valid=0. A dequeue attempt has no effect. The out_* ports show the empty values listed under Ports.
- Flush=1 at an edge:
  - pointers and count go to 0, and any enqueue or dequeue in that cycle is dropped.
  - in_ready is not gated by flush; a beat handshaken in a flush cycle is lost by design.
- Predecode is combinational on in_instr and is registered alongside the entry. Opcode is instr[6:0]; funct3 is instr[14:12].
  - LUI, AUIPC, OP-IMM: class alu.
  - OP: class alu, or muldiv when instr[25]=1.
  - JAL, JALR: class jump.
  - BRANCH: class branch.
  - LOAD: class load.
  - STORE: class store.
  - MISC-MEM: class alu.
  - SYSTEM with funct3=0: class system. SYSTEM with funct3 != 0: class csr.
- An illegal entry has out_class=0 and out_illegal=1. An instruction is illegal when any of the following holds:
  - instr[1:0] != 2'b11;
  - unknown opcode;
  - BRANCH with funct3 of 2 or 3;
  - LOAD with funct3 of 3, 6 or 7;
  - STORE with funct3 of 3 or more;
  - OP-IMM shift with instr[25]=1;
  - OP muldiv when MULDIV_EN=0;
  - MISC-MEM with funct3 not in {0, 1 when FENCEI_EN};
  - SYSTEM with funct3=4;
  - SYSTEM with funct3=0 and instr[31:20] not in {ecall 000, ebreak 001, mret 302, wfi 105}.
- The queue never interprets entries beyond predecode. Illegal entries flow through in order.

Decomposition:
- Shared constants package:
  - opcode and funct3 constants (existing ones reused);
  - the nop constant;
  - class bit index constants.
- New typedef predecode_out_type {class[7:0], illegal} goes in the shared wires package.
- One natural sub-module: predecoder. It is purely combinational, instr -> predecode_out_type, and parametrised by MULDIV_EN and FENCEI_EN.
- Queue storage, pointers and count live in predecode_queue.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, out_instr=32'h00000013, count=0.
- Enqueue 32'h00A50533 (add) at pc 0x100 with out_ready=0:
  - next cycle out_valid=1, out_class=8'b00000001, out_pc=0x100, count=1.
- Fill to DEPTH with out_ready=0:
  - in_ready=0 at count=4; a 5th in_valid is not accepted.
  - Then one dequeue: in_ready returns to 1 a cycle later and FIFO order is preserved across pointer wrap.
- With MULDIV_EN=0, enqueue 32'h02B50533 (mul): out_illegal=1, out_class=0. With MULDIV_EN=1: out_class=8'b00100000.
- Queue holding 3 entries, flush=1 with in_valid=1 and out_ready=1:
  - next cycle count=0, out_valid=0; the flushed-cycle instruction is absent.
- Enqueue 32'h30200073 (mret): class system. Enqueue 32'h00100073 (ebreak): class system. Enqueue 32'h00000000: out_illegal=1.
